// File: rtl/alu_imm_seq_if.sv
// rtl/alu_imm_seq_if.sv - handshake and datapath-strobe bundle for the ALU-immediate sequencer
//
// Purpose: groups the instruction handshake and the datapath control strobes.
// Ports (per signal, seen from the sequencer / slave side):
//   start          in   request, sampled only when the sequencer can accept
//   instr[15:0]    in   [15:12] opcode, [11:6] register index, [5:0] immediate
//   busy           out  high whenever the sequencer is not idle
//   done, error    out  one-cycle completion / rejection pulses
//   pc_inc         out  program counter increment strobe
//   reg_out_en     out  one-hot register-to-bus drive
//   reg_in_en      out  one-hot bus-to-register load
//   alu_in1/2      out  ALU operand latch strobes
//   alu_op[1:0]    out  00 add, 01 sub, 10 and, 11 or
//   alu_out_latch  out  ALU result latch strobe
//   alu_out_en     out  ALU result drive onto bus
//   imm_out_en     out  immediate drive onto bus
//   imm_out        out  extended immediate, valid while imm_out_en
interface alu_imm_seq_if #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 16
);
  logic                start;
  logic [15:0]         instr;
  logic                busy;
  logic                done;
  logic                error;
  logic                pc_inc;
  logic [NUM_REGS-1:0] reg_out_en;
  logic [NUM_REGS-1:0] reg_in_en;
  logic                alu_in1;
  logic                alu_in2;
  logic [1:0]          alu_op;
  logic                alu_out_latch;
  logic                alu_out_en;
  logic                imm_out_en;
  logic [DATA_W-1:0]   imm_out;

  modport master (
    output start, instr,
    input  busy, done, error, pc_inc, reg_out_en, reg_in_en, alu_in1, alu_in2,
           alu_op, alu_out_latch, alu_out_en, imm_out_en, imm_out
  );

  modport slave (
    input  start, instr,
    output busy, done, error, pc_inc, reg_out_en, reg_in_en, alu_in1, alu_in2,
           alu_op, alu_out_latch, alu_out_en, imm_out_en, imm_out
  );
endinterface

// File: rtl/alu_imm_seq.sv
// rtl/alu_imm_seq.sv - ALU-immediate instruction sequencer (fetch, src, imm, exec, drive, writeback)
//
// Purpose: accepts one ADDI/SUBI/ANDI/ORI instruction per start handshake and
// steps the datapath through a fixed strobe sequence; rejects illegal opcodes
// or register indices with a single-cycle error/done pulse.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-low reset
//   bus  slave modport of alu_imm_seq_if (start/instr in, status and strobes out)
// Parameters: NUM_REGS (register count), DATA_W (bus width), IMM_W (immediate width).
// Optional feature: define ALUI_SIGN_EXT_EN to sign-extend the immediate
// (zero-extension otherwise).
module alu_imm_seq #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 6
) (
  input logic         clk,
  input logic         rst,
  alu_imm_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, SRC, IMM, EXEC, DRIVE, WB, DONE, ERR
  } state_t;

  state_t              r_state;
  logic [5:0]          r_idx;
  logic [IMM_W-1:0]    r_imm;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_pc_inc;
  logic [NUM_REGS-1:0] r_reg_out_en;
  logic [NUM_REGS-1:0] r_reg_in_en;
  logic                r_alu_in1;
  logic                r_alu_in2;
  logic [1:0]          r_alu_op;
  logic                r_alu_out_latch;
  logic                r_alu_out_en;
  logic                r_imm_out_en;
  logic [DATA_W-1:0]   r_imm_out;

  logic [3:0]          w_opcode;
  logic [3:0]          w_op_m1;
  logic [5:0]          w_idx;
  logic                w_legal;
  logic [NUM_REGS-1:0] w_idx_onehot;
  logic [DATA_W-1:0]   w_imm_ext;

  assign w_opcode     = bus.instr[15:12];
  assign w_op_m1      = w_opcode - 4'd1;
  assign w_idx        = bus.instr[11:6];
  assign w_legal      = (w_opcode >= 4'd1) && (w_opcode <= 4'd4) && (32'(w_idx) < NUM_REGS);
  assign w_idx_onehot = NUM_REGS'(1) << r_idx;

`ifdef ALUI_SIGN_EXT_EN
  assign w_imm_ext = {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
`else
  assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, r_imm};
`endif

  // Outputs are registered alongside the state so each strobe is high exactly
  // during the cycle its state occupies. DONE also accepts a new start so a
  // continuously requested stream runs at one instruction per 7 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_imm           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_pc_inc        <= 1'b0;
      r_reg_out_en    <= '0;
      r_reg_in_en     <= '0;
      r_alu_in1       <= 1'b0;
      r_alu_in2       <= 1'b0;
      r_alu_op        <= 2'b00;
      r_alu_out_latch <= 1'b0;
      r_alu_out_en    <= 1'b0;
      r_imm_out_en    <= 1'b0;
      r_imm_out       <= '0;
    end else begin
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_pc_inc        <= 1'b0;
      r_reg_out_en    <= '0;
      r_reg_in_en     <= '0;
      r_alu_in1       <= 1'b0;
      r_alu_in2       <= 1'b0;
      r_alu_out_latch <= 1'b0;
      r_alu_out_en    <= 1'b0;
      r_imm_out_en    <= 1'b0;
      r_imm_out       <= '0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_idx    <= w_idx;
            r_imm    <= bus.instr[IMM_W-1:0];
            r_busy   <= 1'b1;
            r_pc_inc <= 1'b1;
            if (w_legal) begin
              r_state  <= FETCH;
              r_alu_op <= w_op_m1[1:0];
            end else begin
              r_state  <= ERR;
              r_alu_op <= 2'b00;
              r_done   <= 1'b1;
              r_error  <= 1'b1;
            end
          end else begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_alu_op <= 2'b00;
          end
        end
        FETCH: begin
          r_state      <= SRC;
          r_reg_out_en <= w_idx_onehot;
          r_alu_in1    <= 1'b1;
        end
        SRC: begin
          r_state      <= IMM;
          r_imm_out_en <= 1'b1;
          r_alu_in2    <= 1'b1;
          r_imm_out    <= w_imm_ext;
        end
        IMM: begin
          r_state         <= EXEC;
          r_alu_out_latch <= 1'b1;
        end
        EXEC: begin
          r_state      <= DRIVE;
          r_alu_out_en <= 1'b1;
        end
        DRIVE: begin
          r_state      <= WB;
          r_alu_out_en <= 1'b1;
          r_reg_in_en  <= w_idx_onehot;
        end
        WB: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        ERR: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_alu_op <= 2'b00;
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_alu_op <= 2'b00;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.pc_inc        = r_pc_inc;
  assign bus.reg_out_en    = r_reg_out_en;
  assign bus.reg_in_en     = r_reg_in_en;
  assign bus.alu_in1       = r_alu_in1;
  assign bus.alu_in2       = r_alu_in2;
  assign bus.alu_op        = r_alu_op;
  assign bus.alu_out_latch = r_alu_out_latch;
  assign bus.alu_out_en    = r_alu_out_en;
  assign bus.imm_out_en    = r_imm_out_en;
  assign bus.imm_out       = r_imm_out;

endmodule

// File: tb/tb_alu_imm_seq.sv
// tb/tb_alu_imm_seq.sv - scoreboard bench for alu_imm_seq with randomized instruction stream
module tb_alu_imm_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_imm_seq_if #(.NUM_REGS(5), .DATA_W(16)) bus ();

  alu_imm_seq #(.NUM_REGS(5), .DATA_W(16), .IMM_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          acc;
    bit          ill;
    int          idx;
    logic [1:0]  op;
    logic [15:0] immx;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n    = 0;
  int   free_edge = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   mon_en    = 0;

  always @(posedge clk) edge_n = edge_n + 1;

  function automatic logic [15:0] ext_imm(input int imm);
`ifdef ALUI_SIGN_EXT_EN
    if (imm >= 32) return 16'(imm + 65536 - 64);
`endif
    return 16'(imm);
  endfunction

  function automatic logic [36:0] model_out(input exp_t e, input int off);
    logic busy, done, error, pc_inc, in1, in2, latch, aoe, ioe;
    logic [4:0] roe, rie;
    logic [1:0] op;
    logic [15:0] imm;
    {busy, done, error, pc_inc, in1, in2, latch, aoe, ioe} = '0;
    roe = '0; rie = '0; op = 2'b00; imm = '0;
    if (e.ill) begin
      if (off == 1) begin busy = 1; done = 1; error = 1; pc_inc = 1; end
    end else if (off >= 1 && off <= 7) begin
      busy = 1;
      op = e.op;
      case (off)
        1: pc_inc = 1;
        2: begin roe = 5'(1 << e.idx); in1 = 1; end
        3: begin ioe = 1; in2 = 1; imm = e.immx; end
        4: latch = 1;
        5: aoe = 1;
        6: begin aoe = 1; rie = 5'(1 << e.idx); end
        default: done = 1;
      endcase
    end
    return {busy, done, error, pc_inc, roe, rie, in1, in2, op, latch, aoe, ioe, imm};
  endfunction

  logic [36:0] m_exp, m_act;
  int          m_off;

  always @(negedge clk) begin
    if (mon_en) begin
      m_exp = '0;
      m_off = 0;
      if (exp_q.size() > 0 && exp_q[0].acc < edge_n) begin
        m_off = edge_n - exp_q[0].acc;
        m_exp = model_out(exp_q[0], m_off);
      end
      m_act = {bus.busy, bus.done, bus.error, bus.pc_inc, bus.reg_out_en, bus.reg_in_en,
               bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_out_latch, bus.alu_out_en,
               bus.imm_out_en, bus.imm_out};
      n_tests = n_tests + 1;
      if (m_act !== m_exp) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs edge=%0d off=%0d got=%h want=%h", edge_n, m_off, m_act, m_exp);
      end
      if (exp_q.size() > 0 && exp_q[0].acc < edge_n &&
          ((exp_q[0].ill && m_off >= 1) || (!exp_q[0].ill && m_off >= 7)))
        void'(exp_q.pop_front());
    end
  end

  task automatic cycle(input logic s, input logic [15:0] ins);
    exp_t e;
    int   opc, idx;
    @(negedge clk);
    #1;
    rst       = 1'b1;
    bus.start = s;
    bus.instr = ins;
    if (s && edge_n >= free_edge) begin
      opc   = int'(ins[15:12]);
      idx   = int'(ins[11:6]);
      e.acc = edge_n;
      e.ill = !(opc >= 1 && opc <= 4 && idx < 5);
      e.idx = idx;
      e.op  = 2'(opc - 1);
      e.immx = ext_imm(int'(ins[5:0]));
      exp_q.push_back(e);
      free_edge = e.ill ? edge_n + 2 : edge_n + 7;
    end
  endtask

  task automatic do_reset();
    logic [36:0] r_act;
    @(negedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.instr = 16'h1085;
    exp_q.delete();
    free_edge = edge_n + 1;
    @(posedge clk);
    #1;
    r_act = {bus.busy, bus.done, bus.error, bus.pc_inc, bus.reg_out_en, bus.reg_in_en,
             bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_out_latch, bus.alu_out_en,
             bus.imm_out_en, bus.imm_out};
    n_tests = n_tests + 1;
    if (r_act !== '0 || bus.busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset state edge=%0d got=%h", edge_n, r_act);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    for (k = 0; k < max_cycles; k++) begin
      if (bus.busy === 1'b0) break;
      cycle(0, 16'h0000);
    end
    n_tests = n_tests + 1;
    if (bus.busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL wait for idle expired after %0d cycles", max_cycles);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] opc;
    logic [5:0] idx, imm;
    int sel;
    sel = $urandom % 8;
    imm = 6'($urandom);
    opc = 4'(1 + $urandom % 4);
    idx = 6'($urandom % 5);
    if (sel == 0) return 16'($urandom);
    if (sel == 1) idx = 6'(5 + $urandom % 59);
    return {opc, idx, imm};
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.instr = 16'h0000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    free_edge = edge_n;
    @(negedge clk);
    mon_en = 1;

    cycle(1, 16'h1085);
    repeat (8) cycle(0, rand_instr());
    cycle(1, 16'h403F);
    repeat (8) cycle(0, rand_instr());
    cycle(1, 16'h1140);
    repeat (2) cycle(0, 16'h0000);
    cycle(1, 16'h7000);
    repeat (2) cycle(0, 16'h0000);

    for (int i = 0; i < 30; i++) cycle(1, {4'h2, 6'd0, 6'($urandom)});
    repeat (8) cycle(0, 16'h0000);

    cycle(1, 16'h3045);
    repeat (5) cycle(0, rand_instr());
    do_reset();
    repeat (3) cycle(0, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      if ($urandom % 60 == 0) do_reset();
      else cycle(($urandom % 3) == 0, rand_instr());
    end
    repeat (10) cycle(0, 16'h0000);
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
